// File: rtl/mpu_bus_responder.sv
// Memory-side responder for the 6502 bus: zero-wait on-chip RAM and STATUS,
// all other addresses forwarded over a req/ack port while RDY stalls the MPU.
module mpu_bus_responder #(
    parameter int          RAM_AW  = 9,
    parameter logic [15:0] IO_ADDR = 16'h0200,
    parameter int          TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        R_W,
    input  logic [7:0]  ABL,
    input  logic [7:0]  ABH,
    input  logic [7:0]  DB_OUT,
    output logic [7:0]  DB_IN,
    output logic        RDY,
    output logic        EXT_REQ,
    output logic        EXT_WE,
    output logic [15:0] EXT_ADDR,
    output logic [7:0]  EXT_WDATA,
    input  logic [7:0]  EXT_RDATA,
    input  logic        EXT_ACK,
    output logic [1:0]  STATE_DBG
);

    // External handshake: EXT_REQ rises when WAIT is entered and stays high until
    // the cycle EXT_ACK is seen (single-cycle pulse) or the timeout fires; an ack
    // outside WAIT has no effect, and RDY=0 tells the MPU to hold the bus unchanged.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          DEPTH   = 1 << RAM_AW;
    localparam logic [15:0] RAM_TOP = 16'(DEPTH);
    localparam logic [7:0]  CNT_MAX = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  rdata_q;
    logic        to_q;
    logic        ext_req_q;
    logic        ext_we_q;
    logic [15:0] ext_addr_q;
    logic [7:0]  ext_wdata_q;
    logic [7:0]  mem [DEPTH];

    logic [15:0] addr;
    logic        ram_hit;
    logic        io_hit;
    logic        ext_hit;
    logic        rdy;

    assign addr    = {ABH, ABL};
    assign ram_hit = addr < RAM_TOP;
    assign io_hit  = addr == IO_ADDR;
    assign ext_hit = !ram_hit && !io_hit;

    // Reset releases the MPU immediately, even with an external address on the bus.
    assign rdy = !RES_N || !((state_q == S_IDLE && ext_hit) || state_q == S_WAIT);

    always_ff @(posedge CLK) begin
        if (ram_hit && !R_W && rdy) begin
            mem[addr[RAM_AW-1:0]] <= DB_OUT;
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            rdata_q     <= 8'd0;
            to_q        <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'd0;
            ext_wdata_q <= 8'd0;
        end else begin
            if (io_hit && !R_W && rdy) begin
                to_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (ext_hit) begin
                        ext_addr_q  <= addr;
                        ext_we_q    <= !R_W;
                        ext_wdata_q <= DB_OUT;
                        cnt_q       <= 8'd0;
                        ext_req_q   <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (EXT_ACK) begin
                        if (!ext_we_q) begin
                            rdata_q <= EXT_RDATA;
                        end
                        ext_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        rdata_q   <= 8'hFF;
                        to_q      <= 1'b1;
                        ext_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    ext_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        DB_IN = rdata_q;
        if (ram_hit) begin
            DB_IN = mem[addr[RAM_AW-1:0]];
        end else if (io_hit) begin
            DB_IN = {7'b0, to_q};
        end
    end

    assign RDY       = rdy;
    assign EXT_REQ   = ext_req_q;
    assign EXT_WE    = ext_we_q;
    assign EXT_ADDR  = ext_addr_q;
    assign EXT_WDATA = ext_wdata_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_mpu_bus_responder.sv
// Bench for mpu_bus_responder: directed scenarios plus a randomized mix checked
// against a memory/status model computed from the access rules.
module tb_mpu_bus_responder;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RES_N;
    logic        R_W;
    logic [7:0]  ABL;
    logic [7:0]  ABH;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN;
    logic        RDY;
    logic        EXT_REQ;
    logic        EXT_WE;
    logic [15:0] EXT_ADDR;
    logic [7:0]  EXT_WDATA;
    logic [7:0]  EXT_RDATA;
    logic        EXT_ACK;
    logic [1:0]  STATE_DBG;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [512];
    int         written_q[$];
    logic [7:0] exp_q[$];
    logic       to_m;
    logic [7:0] rdata_m;

    mpu_bus_responder #(.RAM_AW(9), .IO_ADDR(16'h0200), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RES_N(RES_N), .R_W(R_W), .ABL(ABL), .ABH(ABH), .DB_OUT(DB_OUT),
        .DB_IN(DB_IN), .RDY(RDY), .EXT_REQ(EXT_REQ), .EXT_WE(EXT_WE),
        .EXT_ADDR(EXT_ADDR), .EXT_WDATA(EXT_WDATA), .EXT_RDATA(EXT_RDATA),
        .EXT_ACK(EXT_ACK), .STATE_DBG(STATE_DBG)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic set_bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
        {ABH, ABL} = a;
        R_W = rw;
        DB_OUT = d;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic ram_write(input int a, input logic [7:0] d);
        set_bus(16'(a), 1'b0, d);
        EXT_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if (RDY !== 1'b1) begin
            errors++;
            $display("FAIL ram_wr_rdy: addr %h RDY %b expected 1", a, RDY);
        end
        next_cycle();
        mem_m[a] = d;
        written_q.push_back(a);
    endtask

    task automatic ram_read(input int a);
        logic [7:0] e;
        set_bus(16'(a), 1'b1, 8'h00);
        EXT_ACK = 1'b0;
        exp_q.push_back(mem_m[a]);
        @(negedge CLK);
        e = exp_q.pop_front();
        checks++;
        if (RDY !== 1'b1 || DB_IN !== e) begin
            errors++;
            $display("FAIL ram_rd: addr %h got DB_IN %h RDY %b expected %h RDY 1", a, DB_IN, RDY, e);
        end
        next_cycle();
    endtask

    task automatic status_read();
        set_bus(16'h0200, 1'b1, 8'h00);
        @(negedge CLK);
        checks++;
        if (RDY !== 1'b1 || DB_IN !== {7'b0, to_m}) begin
            errors++;
            $display("FAIL status_rd: got %h RDY %b expected %h RDY 1", DB_IN, RDY, {7'b0, to_m});
        end
        next_cycle();
    endtask

    task automatic status_write();
        set_bus(16'h0200, 1'b0, 8'($urandom));
        @(negedge CLK);
        checks++;
        if (RDY !== 1'b1) begin
            errors++;
            $display("FAIL status_wr_rdy: RDY %b expected 1", RDY);
        end
        next_cycle();
        to_m = 1'b0;
    endtask

    // One external access; d = WAIT cycle (1-based) on which EXT_ACK is pulsed.
    task automatic run_ext(input logic [15:0] a, input logic we, input logic [7:0] wd,
                           input int d, input logic [7:0] ad);
        int n;
        int rdy_low;
        int req_hi;
        n = (d <= TIMEOUT) ? d : TIMEOUT;
        rdy_low = 0;
        req_hi = 0;
        set_bus(a, !we, wd);
        EXT_ACK = 1'b0;
        @(negedge CLK);
        if (RDY === 1'b0) rdy_low++;
        checks++;
        if (EXT_REQ !== 1'b0) begin
            errors++;
            $display("FAIL ext_addr_cycle_req: EXT_REQ %b expected 0", EXT_REQ);
        end
        next_cycle();
        for (int k = 1; k <= n; k++) begin
            EXT_ACK = (k == d);
            EXT_RDATA = (k == d) ? ad : 8'($urandom);
            @(negedge CLK);
            if (RDY === 1'b0) rdy_low++;
            if (EXT_REQ === 1'b1) req_hi++;
            if (k == 1) begin
                checks++;
                if (EXT_ADDR !== a || EXT_WE !== we || EXT_WDATA !== wd) begin
                    errors++;
                    $display("FAIL ext_latch: got addr %h we %b wdata %h expected %h %b %h",
                             EXT_ADDR, EXT_WE, EXT_WDATA, a, we, wd);
                end
            end
            next_cycle();
        end
        if (d <= TIMEOUT) begin
            if (!we) rdata_m = ad;
        end else begin
            rdata_m = 8'hFF;
            to_m = 1'b1;
        end
        EXT_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if (RDY !== 1'b1 || EXT_REQ !== 1'b0 || DB_IN !== rdata_m) begin
            errors++;
            $display("FAIL ext_done: got RDY %b REQ %b DB_IN %h expected 1 0 %h",
                     RDY, EXT_REQ, DB_IN, rdata_m);
        end
        checks++;
        if (rdy_low != n + 1 || req_hi != n) begin
            errors++;
            $display("FAIL ext_cycles: got rdy_low %0d req_hi %0d expected %0d %0d",
                     rdy_low, req_hi, n + 1, n);
        end
        next_cycle();
        set_bus(16'h0000, 1'b1, 8'h00);
        @(negedge CLK);
        checks++;
        if (RDY !== 1'b1 || EXT_REQ !== 1'b0) begin
            errors++;
            $display("FAIL ext_after_done: got RDY %b REQ %b expected 1 0", RDY, EXT_REQ);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        RES_N = 1'b0;
        EXT_ACK = 1'b0;
        EXT_RDATA = 8'h00;
        set_bus(16'h8000, 1'b1, 8'h00);
        to_m = 1'b0;
        rdata_m = 8'h00;
        #12;
        checks++;
        if (RDY !== 1'b1 || EXT_REQ !== 1'b0 || EXT_WE !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got RDY %b REQ %b WE %b expected 1 0 0", RDY, EXT_REQ, EXT_WE);
        end
        checks++;
        if (EXT_ADDR !== 16'h0000 || EXT_WDATA !== 8'h00 || DB_IN !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got addr %h wdata %h DB_IN %h expected 0000 00 00",
                     EXT_ADDR, EXT_WDATA, DB_IN);
        end
        set_bus(16'h0200, 1'b1, 8'h00);
        @(negedge CLK);
        RES_N = 1'b1;
        next_cycle();
        status_read();
    endtask

    task automatic test_ram();
        ram_write(16'h0010, 8'h5A);
        ram_read(16'h0010);
        ram_write(16'h01FF, 8'hC3);
        ram_read(16'h01FF);
        ram_read(16'h0010);
    endtask

    task automatic test_ext_read();
        run_ext(16'h8000, 1'b0, 8'h00, 1, 8'h77);
    endtask

    task automatic test_ext_write();
        run_ext(16'h4000, 1'b1, 8'h99, 5, 8'h12);
    endtask

    task automatic test_timeout();
        run_ext(16'hC000, 1'b0, 8'h00, 40, 8'h00);
        status_read();
        status_write();
        status_read();
    endtask

    task automatic test_ack_on_timeout();
        run_ext(16'hD123, 1'b0, 8'h00, TIMEOUT, 8'h3C);
        status_read();
    endtask

    task automatic test_stray_ack();
        set_bus(16'h0200, 1'b1, 8'h00);
        EXT_ACK = 1'b1;
        EXT_RDATA = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (RDY !== 1'b1 || EXT_REQ !== 1'b0 || DB_IN !== {7'b0, to_m}) begin
                errors++;
                $display("FAIL stray_ack: got RDY %b REQ %b DB_IN %h expected 1 0 %h",
                         RDY, EXT_REQ, DB_IN, {7'b0, to_m});
            end
            next_cycle();
        end
        EXT_ACK = 1'b0;
        run_ext(16'h0300, 1'b0, 8'h00, 2, 8'hA5);
    endtask

    task automatic test_reset_mid_wait();
        run_ext(16'hE000, 1'b1, 8'h44, 25, 8'h00);
        ram_write(16'h0123, 8'h6B);
        set_bus(16'h9000, 1'b1, 8'h00);
        EXT_ACK = 1'b0;
        next_cycle();
        for (int i = 0; i < 3; i++) next_cycle();
        #2;
        RES_N = 1'b0;
        #1;
        checks++;
        if (EXT_REQ !== 1'b0 || RDY !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: got REQ %b RDY %b expected 0 1", EXT_REQ, RDY);
        end
        to_m = 1'b0;
        rdata_m = 8'h00;
        set_bus(16'h0123, 1'b1, 8'h00);
        @(negedge CLK);
        RES_N = 1'b1;
        next_cycle();
        ram_read(16'h0123);
        status_read();
        run_ext(16'h9000, 1'b0, 8'h00, 3, 8'h5E);
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: ram_write($urandom_range(0, 511), 8'($urandom));
                1: begin
                    if (written_q.size() > 0)
                        ram_read(written_q[$urandom_range(0, written_q.size() - 1)]);
                    else
                        status_read();
                end
                2: status_read();
                3: status_write();
                4: run_ext(16'($urandom_range(16'h0201, 16'hFFFF)), 1'b0, 8'h00,
                           $urandom_range(1, 20), 8'($urandom));
                default: run_ext(16'($urandom_range(16'h0201, 16'hFFFF)), 1'b1, 8'($urandom),
                                 $urandom_range(1, 20), 8'($urandom));
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_ack_on_timeout();
        test_stray_ack();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
